// File: rtl/usb_ptcl_fsm.sv
// Host-side USB protocol engine: sequences token/data/handshake packets for one
// IN or OUT transaction, applies reply timeout and retry limits, and reports
// completion plus the last good IN payload.
module usb_ptcl_fsm #(
    parameter int unsigned TIMEOUT     = 255,
    parameter int unsigned MAX_RETRIES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        txn_start,
    input  logic [1:0]  transaction,
    input  logic [18:0] token_pkt,
    input  logic [71:0] data_pkt,
    output logic        tx_valid,
    output logic [71:0] tx_pkt,
    output logic [1:0]  tx_len,
    input  logic        tx_ready,
    input  logic        rx_valid,
    input  logic [7:0]  rx_pid,
    input  logic [63:0] rx_data,
    input  logic        rx_crc_ok,
    output logic        pkt_sent,
    output logic        txn_done,
    output logic        txn_success,
    output logic [63:0] data_from_ptcl
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned RW = $clog2(MAX_RETRIES + 1);

    localparam logic [7:0] PID_ACK   = 8'b01001011;
    localparam logic [7:0] PID_NAK   = 8'b01011010;
    localparam logic [7:0] PID_DATA0 = 8'b11000011;

    typedef enum logic [2:0] {
        IDLE,
        SEND_TOK,
        SEND_DATA,
        WAIT_HS,
        WAIT_DATA,
        SEND_HS,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic          is_in_q, is_in_d;
    logic [18:0]   token_q, token_d;
    logic [71:0]   data_q, data_d;
    logic [7:0]    hs_pid_q, hs_pid_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          success_q, success_d;
    logic [63:0]   rx_data_q, rx_data_d;

    logic          err;
    logic [RW-1:0] retry_inc;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            is_in_q   <= 1'b0;
            token_q   <= '0;
            data_q    <= '0;
            hs_pid_q  <= '0;
            retry_q   <= '0;
            tmo_q     <= '0;
            success_q <= 1'b0;
            rx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            is_in_q   <= is_in_d;
            token_q   <= token_d;
            data_q    <= data_d;
            hs_pid_q  <= hs_pid_d;
            retry_q   <= retry_d;
            tmo_q     <= tmo_d;
            success_q <= success_d;
            rx_data_q <= rx_data_d;
        end
    end

    // Next-state, packet offer and reply evaluation; errors resolved after the case
    always_comb begin
        state_d     = state_q;
        is_in_d     = is_in_q;
        token_d     = token_q;
        data_d      = data_q;
        hs_pid_d    = hs_pid_q;
        retry_d     = retry_q;
        tmo_d       = '0;
        success_d   = success_q;
        rx_data_d   = rx_data_q;
        err         = 1'b0;
        retry_inc   = retry_q + 1'b1;
        tx_valid    = 1'b0;
        tx_pkt      = '0;
        tx_len      = 2'd0;
        pkt_sent    = 1'b0;
        txn_done    = 1'b0;
        txn_success = 1'b0;

        case (state_q)
            IDLE: begin
                if (txn_start && (transaction == 2'b01 || transaction == 2'b10)) begin
                    is_in_d   = (transaction == 2'b01);
                    token_d   = token_pkt;
                    data_d    = data_pkt;
                    retry_d   = '0;
                    success_d = 1'b0;
                    state_d   = SEND_TOK;
                end
            end
            SEND_TOK: begin
                tx_valid = 1'b1;
                tx_len   = 2'd1;
                tx_pkt   = {token_q, 53'b0};
                if (tx_ready) begin
                    pkt_sent = 1'b1;
                    state_d  = is_in_q ? WAIT_DATA : SEND_DATA;
                end
            end
            SEND_DATA: begin
                tx_valid = 1'b1;
                tx_len   = 2'd2;
                tx_pkt   = data_q;
                if (tx_ready) state_d = WAIT_HS;
            end
            WAIT_HS: begin
                if (rx_valid) begin
                    if (rx_pid == PID_ACK) begin
                        success_d = 1'b1;
                        state_d   = DONE;
                    end else begin
                        err = 1'b1;
                    end
                end else if (tmo_q == TW'(TIMEOUT)) begin
                    err = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            WAIT_DATA: begin
                if (rx_valid) begin
                    if (rx_pid == PID_DATA0 && rx_crc_ok) begin
                        rx_data_d = rx_data;
                        hs_pid_d  = PID_ACK;
                        success_d = 1'b1;
                        state_d   = SEND_HS;
                    end else begin
                        err = 1'b1;
                    end
                end else if (tmo_q == TW'(TIMEOUT)) begin
                    err = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            SEND_HS: begin
                tx_valid = 1'b1;
                tx_len   = 2'd0;
                tx_pkt   = {hs_pid_q, 64'b0};
                if (tx_ready) state_d = success_q ? DONE : WAIT_DATA;
            end
            DONE: begin
                txn_done    = 1'b1;
                txn_success = success_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // One shared error path for both wait states: count it, then either give up or retry
        if (err) begin
            retry_d = retry_inc;
            if (retry_inc == RW'(MAX_RETRIES)) begin
                success_d = 1'b0;
                state_d   = DONE;
            end else if (is_in_q) begin
                hs_pid_d = PID_NAK;
                state_d  = SEND_HS;
            end else begin
                state_d = SEND_DATA;
            end
        end
    end

    assign data_from_ptcl = rx_data_q;

endmodule
